// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down counter: default width and
// the FSM state encoding.
package down_counter_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : down_counter_pkg

// File: rtl/down_counter_4.sv
// Loadable, enabled down counter with a one-cycle terminal-count pulse,
// a sticky expiry flag, and optional auto-reload for periodic ticks.
module down_counter_4
  import down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             CLEAR_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             RELOAD,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             EXPIRED
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  state_t           r_state;

  logic             w_terminal;
  logic             w_load_nonzero;

  assign w_terminal     = (r_q == WIDTH'(1));
  assign w_load_nonzero = (D != '0);

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so the order of statements below cannot create races.
  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      r_tc <= 1'b0;
      if (LOAD) begin
        // A load overrides everything, including a coincident terminal edge.
        r_q      <= D;
        r_reload <= D;
        r_state  <= w_load_nonzero ? ST_RUN : ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_RUN: begin
            if (EN) begin
              if (w_terminal) begin
                r_tc <= 1'b1;
                if (RELOAD) begin
                  r_q <= r_reload;
                end else begin
                  r_q     <= '0;
                  r_state <= ST_DONE;
                end
              end else begin
                r_q <= r_q - WIDTH'(1);
              end
            end
          end
          ST_DONE: begin
            r_q <= '0;
            if (ACK) r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Q       = r_q;
  assign TC      = r_tc;
  assign BUSY    = (r_state == ST_RUN);
  assign EXPIRED = (r_state == ST_DONE);

endmodule : down_counter_4

// File: tb/tb_down_counter_4.sv
// Scoreboard bench for down_counter_4: expectations are queued as stimulus
// is driven and compared against outputs captured one edge later.
module tb_down_counter_4;

  logic       CLOCK;
  logic       CLEAR_N;
  logic       LOAD;
  logic [3:0] D;
  logic       EN;
  logic       RELOAD;
  logic       ACK;
  logic [3:0] Q;
  logic       TC;
  logic       BUSY;
  logic       EXPIRED;

  typedef struct {
    string      name;
    logic [6:0] outs;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] obs_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  down_counter_4 #(.WIDTH(4)) dut (
    .CLOCK   (CLOCK),
    .CLEAR_N (CLEAR_N),
    .LOAD    (LOAD),
    .D       (D),
    .EN      (EN),
    .RELOAD  (RELOAD),
    .ACK     (ACK),
    .Q       (Q),
    .TC      (TC),
    .BUSY    (BUSY),
    .EXPIRED (EXPIRED)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Drive one cycle of stimulus, queue what the outputs must be after the
  // edge, then capture what the DUT actually shows.
  task automatic cyc(input string name, input logic ld, input logic [3:0] d,
                     input logic en, input logic rl, input logic ack,
                     input logic [3:0] q, input logic tc, input logic busy,
                     input logic expd);
    LOAD   = ld;
    D      = d;
    EN     = en;
    RELOAD = rl;
    ACK    = ack;
    exp_q.push_back('{name, {q, tc, busy, expd}});
    @(posedge CLOCK);
    #1;
    obs_q.push_back({Q, TC, BUSY, EXPIRED});
  endtask

  // Pulse CLEAR_N between edges; outputs must already be cleared while it is low.
  task automatic async_pulse(input string name);
    #3;
    CLEAR_N = 1'b0;
    #1;
    exp_q.push_back('{name, 7'b0000_000});
    obs_q.push_back({Q, TC, BUSY, EXPIRED});
    #1;
    CLEAR_N = 1'b1;
  endtask

  task automatic test_reset();
    #20;
    exp_q.push_back('{"reset_held", 7'b0000_000});
    obs_q.push_back({Q, TC, BUSY, EXPIRED});
    #14;
    CLEAR_N = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle_en", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  task automatic test_one_shot();
    cyc("os_load", 1, 4'd5, 0, 0, 0, 4'd5, 0, 1, 0);
    for (int i = 4; i >= 1; i--)
      cyc("os_count", 0, 4'd0, 1, 0, 0, 4'(i), 0, 1, 0);
    cyc("os_expire", 0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1);
    cyc("os_sticky", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
    cyc("os_ack",    0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    cyc("idle_ack",  0, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  task automatic test_enable_gating();
    cyc("eg_load", 1, 4'd3, 0, 0, 0, 4'd3, 0, 1, 0);
    cyc("eg_en1",  0, 4'd0, 1, 0, 0, 4'd2, 0, 1, 0);
    cyc("eg_hold", 0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0);
    cyc("eg_hold", 0, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0);
    cyc("eg_en2",  0, 4'd0, 1, 0, 0, 4'd1, 0, 1, 0);
    cyc("eg_exp",  0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1);
    cyc("eg_ack",  0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  task automatic test_auto_reload();
    cyc("ar_load", 1, 4'd4, 0, 1, 0, 4'd4, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] q_exp;
      q_exp = (i % 4 == 3) ? 4'd4 : 4'(3 - (i % 4));
      cyc("ar_period", 0, 4'd0, 1, 1, 0, q_exp, (i % 4 == 3), 1, 0);
    end
    // RELOAD only matters at the terminal edge.
    cyc("ar_toggle", 0, 4'd0, 1, 0, 0, 4'd3, 0, 1, 0);
    cyc("ar_toggle", 0, 4'd0, 1, 1, 0, 4'd2, 0, 1, 0);
    cyc("ar_toggle", 0, 4'd0, 1, 1, 0, 4'd1, 0, 1, 0);
    cyc("ar_stop",   0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1);
    cyc("ar_ack",    0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  task automatic test_load_collision();
    cyc("lc_load2",   1, 4'd2, 0, 0, 0, 4'd2, 0, 1, 0);
    cyc("lc_count",   0, 4'd0, 1, 0, 0, 4'd1, 0, 1, 0);
    cyc("lc_collide", 1, 4'd9, 1, 0, 0, 4'd9, 0, 1, 0);
    cyc("lc_zero",    1, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0);
    cyc("lc_zero_en", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
    cyc("lc_max",     1, 4'd15, 0, 0, 0, 4'd15, 0, 1, 0);
    for (int i = 14; i >= 1; i--)
      cyc("lc_max_cnt", 0, 4'd0, 1, 0, 0, 4'(i), 0, 1, 0);
    cyc("lc_max_exp", 0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1);
    cyc("lc_done_en", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1);
    cyc("lc_ack",     0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc("rs_load", 1, 4'd12, 0, 0, 0, 4'd12, 0, 1, 0);
    for (int i = 11; i >= 7; i--)
      cyc("rs_count", 0, 4'd0, 1, 0, 0, 4'(i), 0, 1, 0);
    async_pulse("rs_mid_run");
    for (int i = 0; i < 3; i++) cyc("rs_idle", 0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0);
    cyc("rs_load1", 1, 4'd1, 0, 0, 0, 4'd1, 0, 1, 0);
    cyc("rs_tc",    0, 4'd0, 1, 0, 0, 4'd0, 1, 0, 1);
    async_pulse("rs_in_tc");
    cyc("rs_after", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      logic [6:0] o = (obs_q.size() > 0) ? obs_q.pop_front() : 7'bx;
      n_checks++;
      if (o !== e.outs) begin
        n_errors++;
        $display("FAIL %s: got q/tc/busy/exp=%b required %b", e.name, o, e.outs);
      end
    end
  endtask

  initial begin
    CLEAR_N = 1'b0;
    LOAD    = 1'b0;
    D       = 4'd0;
    EN      = 1'b1;
    RELOAD  = 1'b0;
    ACK     = 1'b0;
    test_reset();
    test_one_shot();
    test_enable_gating();
    test_auto_reload();
    test_load_collision();
    test_async_reset();
    n_checks++;
    if (obs_q.size() !== 0) begin
      n_errors++;
      $display("FAIL leftover_obs: got %0d unmatched samples required 0", obs_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_down_counter_4
